// File: rtl/fft_spectrum_reader.sv
// rtl/fft_spectrum_reader.sv - two-bank ping-pong capture of FFT magnitude frames with valid/ready replay
// Optional peak tracker enabled by FFT_SPECTRUM_PEAK_EN.
module fft_spectrum_reader #(
    parameter int FFT_LEN = 1024,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mag_valid,
    input  logic [DATA_W-1:0] mag_data,
    input  logic              frame_sync,
    input  logic              rd_start,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              peak_valid,
    output logic [DATA_W-1:0] peak_mag,
    output logic [ADDR_W-1:0] peak_bin
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FFT_LEN - 1);

    typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [2*FFT_LEN];
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_idx;
    logic [1:0]        bank_full;
    logic              drop;
    logic              rd_bank;
    logic [ADDR_W:0]   rd_addr;
    logic [DATA_W-1:0] q_data;
    logic              q_valid;
    logic              q_last;

    logic              frame_start;
    logic [ADDR_W-1:0] idx_eff;
    logic              free_now;
    logic              target_busy;
    logic              cur_drop;
    logic              we;
    logic              complete;
    logic              out_free;
    logic              issue;
    logic [1:0]        free_mask;
    logic [1:0]        set_mask;

    // A bank being released this cycle counts as free when deciding whether to drop.
    always_comb begin
        frame_start = frame_sync || (wr_idx == '0);
        idx_eff     = frame_sync ? '0 : wr_idx;
        free_now    = (state == STREAM) && rd_valid && rd_ready && rd_last;
        target_busy = bank_full[wr_bank] && !(free_now && (rd_bank == wr_bank));
        cur_drop    = frame_start ? target_busy : drop;
        we          = mag_valid && !cur_drop;
        complete    = we && (idx_eff == LAST);
        out_free    = !rd_valid || rd_ready;
        issue       = (state != IDLE) && !rd_addr[ADDR_W] && (out_free || !q_valid);
        free_mask   = free_now ? (2'b01 << rd_bank) : 2'b00;
        set_mask    = complete ? (2'b01 << wr_bank) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[{wr_bank, idx_eff}] <= mag_data;
        if (issue)
            q_data <= mem[{rd_bank, rd_addr[ADDR_W-1:0]}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_bank    <= 1'b0;
            wr_idx     <= '0;
            bank_full  <= 2'b00;
            drop       <= 1'b0;
            rd_bank    <= 1'b0;
            rd_addr    <= '0;
            q_valid    <= 1'b0;
            q_last     <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            rd_last    <= 1'b0;
            rd_busy    <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= complete;
            bank_full  <= (bank_full & ~free_mask) | set_mask;

            if (mag_valid) begin
                drop <= cur_drop;
                if (frame_start && cur_drop)
                    overflow <= 1'b1;
                if (idx_eff == LAST)
                    wr_idx <= '0;
                else
                    wr_idx <= idx_eff + 1'b1;
                if (complete)
                    wr_bank <= ~wr_bank;
            end else if (frame_sync) begin
                wr_idx <= '0;
            end

            // q_* is the prefetch stage behind the output register; it refills whenever it drains.
            if (issue) begin
                q_valid <= 1'b1;
                q_last  <= (rd_addr[ADDR_W-1:0] == LAST);
                rd_addr <= rd_addr + 1'b1;
            end else if (out_free) begin
                q_valid <= 1'b0;
            end

            if (out_free) begin
                rd_valid <= q_valid;
                rd_last  <= q_valid && q_last;
                if (q_valid)
                    rd_data <= q_data;
            end

            case (state)
                IDLE: begin
                    if (rd_start && (bank_full != 2'b00)) begin
                        state   <= PRIME;
                        rd_busy <= 1'b1;
                        rd_addr <= '0;
                        // With both banks full the older one is the bank the writer would reuse next.
                        rd_bank <= (&bank_full) ? wr_bank : bank_full[1];
                    end
                end
                PRIME: state <= STREAM;
                STREAM: begin
                    if (free_now) begin
                        state   <= IDLE;
                        rd_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FFT_SPECTRUM_PEAK_EN
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(FFT_LEN / 2 - 1);

    logic [DATA_W-1:0] pk_max;
    logic [ADDR_W-1:0] pk_bin;

    // Bin 1 seeds the search each frame so stale values from dropped frames never leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_max     <= '0;
            pk_bin     <= '0;
            peak_valid <= 1'b0;
            peak_mag   <= '0;
            peak_bin   <= '0;
        end else begin
            peak_valid <= complete;
            if (we && (idx_eff != '0) && (idx_eff <= HALF) &&
                ((idx_eff == ADDR_W'(1)) || (mag_data > pk_max))) begin
                pk_max <= mag_data;
                pk_bin <= idx_eff;
            end
            if (complete) begin
                peak_mag <= pk_max;
                peak_bin <= pk_bin;
            end
        end
    end
`else
    assign peak_valid = 1'b0;
    assign peak_mag   = '0;
    assign peak_bin   = '0;
`endif
endmodule

// File: tb/tb_fft_spectrum_reader.sv
// tb/tb_fft_spectrum_reader.sv - scoreboard bench for fft_spectrum_reader with FFT_LEN=16
module tb_fft_spectrum_reader;
    localparam int FFT_LEN = 16;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              mag_valid;
    logic [DATA_W-1:0] mag_data;
    logic              frame_sync;
    logic              rd_start;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_busy;
    logic              frame_done;
    logic              overflow;
    logic              peak_valid;
    logic [DATA_W-1:0] peak_mag;
    logic [ADDR_W-1:0] peak_bin;

    fft_spectrum_reader #(.FFT_LEN(FFT_LEN), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .mag_valid(mag_valid), .mag_data(mag_data),
        .frame_sync(frame_sync), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_busy(rd_busy),
        .frame_done(frame_done), .overflow(overflow), .peak_valid(peak_valid),
        .peak_mag(peak_mag), .peak_bin(peak_bin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fd_count = 0;
    int hs_count = 0;
    bit stall_mode = 1'b0;
    logic [DATA_W:0] exp_q[$];

    bit              stalled_prev = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic            prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [DATA_W-1:0] gen(input int kind, input int bin);
        case (kind)
            0: return 16'(bin * 3);
            1: return 16'(16'h0100 + bin);
            2: return 16'(16'h0200 + bin);
            3: return 16'(16'h0300 + bin);
            4: return 16'h00AA;
            5: return 16'(16'h5000 + bin * 7);
            default: begin
                if (bin == 0) return 16'hFFFF;
                if (bin == 3 || bin == 6) return 16'h0200;
                if (bin == 12) return 16'h0FFF;
                return 16'h0010;
            end
        endcase
    endfunction

    // Scoreboard monitor: pops one expected sample per handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_done) fd_count++;
            if (stalled_prev) begin
                check("stall_valid", {31'b0, rd_valid}, 32'd1);
                check("stall_data", {16'b0, rd_data}, {16'b0, prev_data});
                check("stall_last", {31'b0, rd_last}, {31'b0, prev_last});
            end
            if (rd_valid && rd_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_sample", {16'b0, rd_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [DATA_W:0] e;
                    e = exp_q.pop_front();
                    check("rd_data", {16'b0, rd_data}, {16'b0, e[DATA_W-1:0]});
                    check("rd_last", {31'b0, rd_last}, {31'b0, e[DATA_W]});
                end
            end
            stalled_prev = rd_valid && !rd_ready;
            prev_data    = rd_data;
            prev_last    = rd_last;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    // Ready driver: steady high, or the repeating 1,0,0 pattern.
    initial begin
        int ph = 0;
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                rd_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                rd_ready = 1'b1;
            end
        end
    end

    task automatic write_samples(input int kind, input int n, input bit sync_first);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mag_valid  = 1'b1;
            mag_data   = gen(kind, i);
            frame_sync = sync_first && (i == 0);
        end
        @(posedge clk); #1;
        mag_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic replay(input int kind, input bit check_lat);
        int n = 0;
        for (int b = 0; b < FFT_LEN; b++)
            exp_q.push_back({(b == FFT_LEN - 1), gen(kind, b)});
        @(posedge clk); #1 rd_start = 1'b1;
        @(posedge clk); #1 rd_start = 1'b0;
        if (check_lat) begin
            @(negedge clk);
            check("lat_prime_valid", {31'b0, rd_valid}, 32'd0);
            check("lat_prime_busy", {31'b0, rd_busy}, 32'd1);
            @(negedge clk);
            check("lat_cycle1_valid", {31'b0, rd_valid}, 32'd0);
            @(negedge clk);
            check("lat_cycle2_valid", {31'b0, rd_valid}, 32'd1);
        end
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_remaining", exp_q.size(), 32'd0);
        @(negedge clk);
        check("end_busy", {31'b0, rd_busy}, 32'd0);
        check("end_valid", {31'b0, rd_valid}, 32'd0);
    endtask

    initial begin
        int fd0;
        int hs0;
        int n;
        rst_n      = 1'b0;
        mag_valid  = 1'b0;
        mag_data   = '0;
        frame_sync = 1'b0;
        rd_start   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_rd_data", {16'b0, rd_data}, 32'd0);
        check("rst_rd_last", {31'b0, rd_last}, 32'd0);
        check("rst_rd_busy", {31'b0, rd_busy}, 32'd0);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_peak", {11'b0, peak_valid, peak_mag, peak_bin}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single frame, full-throughput replay.
        fd0 = fd_count;
        write_samples(0, FFT_LEN, 1'b0);
        @(negedge clk);
        check("t1_frame_done_pulse", {31'b0, frame_done}, 32'd1);
        @(posedge clk); @(negedge clk);
        check("t1_frame_done_count", fd_count - fd0, 32'd1);
        replay(0, 1'b1);

        // Stalled replay.
        write_samples(5, FFT_LEN, 1'b0);
        stall_mode = 1'b1;
        hs0 = hs_count;
        replay(5, 1'b0);
        stall_mode = 1'b0;
        check("t2_handshakes", hs_count - hs0, 32'd16);

        // Three frames without reading: third one dropped.
        fd0 = fd_count;
        write_samples(1, FFT_LEN, 1'b0);
        write_samples(2, FFT_LEN, 1'b0);
        write_samples(3, FFT_LEN, 1'b0);
        @(posedge clk); @(negedge clk);
        check("t3_frame_done_count", fd_count - fd0, 32'd2);
        check("t3_overflow", {31'b0, overflow}, 32'd1);
        replay(1, 1'b0);
        replay(2, 1'b0);

        // Resync after a partial frame.
        fd0 = fd_count;
        write_samples(0, 7, 1'b0);
        @(posedge clk); @(negedge clk);
        check("t4_partial_no_done", fd_count - fd0, 32'd0);
        write_samples(4, FFT_LEN, 1'b1);
        @(posedge clk); @(negedge clk);
        check("t4_frame_done_count", fd_count - fd0, 32'd1);
        replay(4, 1'b0);

        // Reset while streaming at bin 5.
        write_samples(1, FFT_LEN, 1'b0);
        for (int b = 0; b < FFT_LEN; b++)
            exp_q.push_back({(b == FFT_LEN - 1), gen(1, b)});
        @(posedge clk); #1 rd_start = 1'b1;
        @(posedge clk); #1 rd_start = 1'b0;
        n = 0;
        while (exp_q.size() != 11 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("t5_reached_bin5", exp_q.size(), 32'd11);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_valid", {31'b0, rd_valid}, 32'd0);
        check("t5_rst_busy", {31'b0, rd_busy}, 32'd0);
        check("t5_rst_overflow", {31'b0, overflow}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 rd_start = 1'b1;
        @(posedge clk); #1 rd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_ignored_busy", {31'b0, rd_busy}, 32'd0);
            check("t5_ignored_valid", {31'b0, rd_valid}, 32'd0);
        end

`ifdef FFT_SPECTRUM_PEAK_EN
        write_samples(6, FFT_LEN, 1'b0);
        @(negedge clk);
        check("t6_frame_done", {31'b0, frame_done}, 32'd1);
        check("t6_peak_valid", {31'b0, peak_valid}, 32'd1);
        check("t6_peak_mag", {16'b0, peak_mag}, 32'h0200);
        check("t6_peak_bin", {28'b0, peak_bin}, 32'd3);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
